// File: rtl/dma_pkg.sv
// Shared types and defaults for the DMA burst controller.
package dma_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        XFER = 2'd2,
        DONE = 2'd3
    } dma_state_e;

    localparam int DMA_DEF_LEN = 100;

endpackage

// File: rtl/dma_beat_cnt.sv
// Beat counter: load latches the burst length and clears the count;
// last flags the final beat (count == len-1).
module dma_beat_cnt #(
    parameter int LEN_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [LEN_W-1:0] len,
    input  logic             inc,
    output logic [LEN_W-1:0] count,
    output logic             last
);

    logic [LEN_W-1:0] len_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            len_q <= '0;
            count <= '0;
        end else if (load) begin
            len_q <= len;
            count <= '0;
        end else if (inc) begin
            count <= count + LEN_W'(1);
        end
    end

    // Only meaningful while transferring, where len_q is always nonzero.
    assign last = (count == (len_q - LEN_W'(1)));

endmodule

// File: rtl/dma_burst_ctrl.sv
// DMA burst controller: IDLE -> REQ -> XFER (N beats) -> DONE, with abort,
// default-length substitution and zero-length rejection. Outputs are registered.
module dma_burst_ctrl
    import dma_pkg::*;
#(
    parameter int LEN_W   = 8,
    parameter int DEF_LEN = DMA_DEF_LEN
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [LEN_W-1:0] burst_len,
    input  logic             use_def,
    input  logic             abort,
    output logic             dma_req,
    output logic             data_transfer,
    output logic             done,
    output logic             aborted,
    output logic             busy,
    output logic [LEN_W-1:0] beat_cnt,
    output logic             len_err
);

    if (DEF_LEN > (2 ** LEN_W) - 1) begin : g_def_len_check
        $error("DEF_LEN does not fit in LEN_W bits");
    end

    localparam logic [LEN_W-1:0] DEF_LEN_V = LEN_W'(DEF_LEN);

    dma_state_e       state, state_nxt;
    logic [LEN_W-1:0] eff_len;
    logic             cnt_load, cnt_inc, cnt_last;
    logic             dma_req_nxt, xfer_nxt, done_nxt, aborted_nxt, busy_nxt, len_err_nxt;

    dma_beat_cnt #(.LEN_W(LEN_W)) u_beat_cnt (
        .clk   (clk),
        .reset (reset),
        .load  (cnt_load),
        .len   (eff_len),
        .inc   (cnt_inc),
        .count (beat_cnt),
        .last  (cnt_last)
    );

    always_comb begin
        eff_len     = (burst_len != '0) ? burst_len : (use_def ? DEF_LEN_V : '0);
        state_nxt   = state;
        cnt_load    = 1'b0;
        cnt_inc     = 1'b0;
        aborted_nxt = 1'b0;
        len_err_nxt = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    if (eff_len != '0) begin
                        state_nxt = REQ;
                        cnt_load  = 1'b1;
                    end else begin
                        len_err_nxt = 1'b1;
                    end
                end
            end
            REQ: begin
                if (abort) begin
                    state_nxt   = DONE;
                    aborted_nxt = 1'b1;
                end else begin
                    state_nxt = XFER;
                end
            end
            XFER: begin
                // The beat in flight always counts; the last beat wins over abort.
                cnt_inc = 1'b1;
                if (cnt_last) begin
                    state_nxt = DONE;
                end else if (abort) begin
                    state_nxt   = DONE;
                    aborted_nxt = 1'b1;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        dma_req_nxt = (state_nxt == REQ) || (state_nxt == XFER);
        xfer_nxt    = (state_nxt == XFER);
        done_nxt    = (state_nxt == DONE);
        busy_nxt    = (state_nxt != IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            dma_req       <= 1'b0;
            data_transfer <= 1'b0;
            done          <= 1'b0;
            aborted       <= 1'b0;
            busy          <= 1'b0;
            len_err       <= 1'b0;
        end else begin
            state         <= state_nxt;
            dma_req       <= dma_req_nxt;
            data_transfer <= xfer_nxt;
            done          <= done_nxt;
            aborted       <= aborted_nxt;
            busy          <= busy_nxt;
            len_err       <= len_err_nxt;
        end
    end

endmodule

// File: tb/tb_dma_burst_ctrl.sv
// Directed self-checking bench for dma_burst_ctrl.
module tb_dma_burst_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [7:0] burst_len;
    logic       use_def;
    logic       abort;
    logic       dma_req, data_transfer, done, aborted, busy, len_err;
    logic [7:0] beat_cnt;

    int checks   = 0;
    int failures = 0;

    dma_burst_ctrl #(.LEN_W(8), .DEF_LEN(100)) dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .burst_len     (burst_len),
        .use_def       (use_def),
        .abort         (abort),
        .dma_req       (dma_req),
        .data_transfer (data_transfer),
        .done          (done),
        .aborted       (aborted),
        .busy          (busy),
        .beat_cnt      (beat_cnt),
        .len_err       (len_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_dma_req"}, 32'(dma_req), 0);
        chk({tag, "_xfer"},    32'(data_transfer), 0);
        chk({tag, "_done"},    32'(done), 0);
        chk({tag, "_aborted"}, 32'(aborted), 0);
        chk({tag, "_busy"},    32'(busy), 0);
        chk({tag, "_beat_cnt"}, 32'(beat_cnt), 0);
        chk({tag, "_len_err"}, 32'(len_err), 0);
    endtask

    // Called in the REQ cycle; walks N beats, DONE and the return to IDLE.
    task automatic expect_burst(input string tag, input int n);
        chk({tag, "_req_dma"},  32'(dma_req), 1);
        chk({tag, "_req_xfer"}, 32'(data_transfer), 0);
        chk({tag, "_req_busy"}, 32'(busy), 1);
        chk({tag, "_req_cnt"},  32'(beat_cnt), 0);
        for (int i = 0; i < n; i++) begin
            tick();
            chk({tag, "_beat_xfer"}, 32'(data_transfer), 1);
            chk({tag, "_beat_dma"},  32'(dma_req), 1);
            chk({tag, "_beat_cnt"},  32'(beat_cnt), 32'(i));
            chk({tag, "_beat_done"}, 32'(done), 0);
        end
        tick();
        chk({tag, "_done"},      32'(done), 1);
        chk({tag, "_done_abt"},  32'(aborted), 0);
        chk({tag, "_done_dma"},  32'(dma_req), 0);
        chk({tag, "_done_xfer"}, 32'(data_transfer), 0);
        chk({tag, "_done_cnt"},  32'(beat_cnt), 32'(n));
        chk({tag, "_done_busy"}, 32'(busy), 1);
        tick();
        chk({tag, "_idle_done"}, 32'(done), 0);
        chk({tag, "_idle_busy"}, 32'(busy), 0);
        chk({tag, "_idle_cnt"},  32'(beat_cnt), 32'(n));
    endtask

    initial begin
        logic [4:0] bb_req, bb_xfer, bb_done, bb_busy;
        bb_req  = 5'b00111;
        bb_xfer = 5'b00110;
        bb_done = 5'b01000;
        bb_busy = 5'b01111;

        reset = 1'b1; start = 1'b0; burst_len = '0; use_def = 1'b0; abort = 1'b0;
        tick();
        tick();
        chk_all_zero("rst");
        reset = 1'b0;

        // 100-beat burst
        start = 1'b1; burst_len = 8'd100;
        tick();
        start = 1'b0;
        expect_burst("b100", 100);

        // default length substitution
        start = 1'b1; burst_len = 8'd0; use_def = 1'b1;
        tick();
        start = 1'b0;
        expect_burst("def", 100);

        // zero length rejected
        start = 1'b1; burst_len = 8'd0; use_def = 1'b0;
        tick();
        start = 1'b0;
        chk("lerr_pulse", 32'(len_err), 1);
        chk("lerr_busy",  32'(busy), 0);
        chk("lerr_dma",   32'(dma_req), 0);
        chk("lerr_cnt",   32'(beat_cnt), 100);
        tick();
        chk("lerr_clear", 32'(len_err), 0);
        chk("lerr_busy2", 32'(busy), 0);

        // abort in IDLE ignored
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("idle_abt_busy", 32'(busy), 0);
        chk("idle_abt_done", 32'(done), 0);

        // abort on 4th beat of 10
        start = 1'b1; burst_len = 8'd10;
        tick();
        start = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        chk("abt4_cnt_before", 32'(beat_cnt), 3);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abt4_done", 32'(done), 1);
        chk("abt4_abt",  32'(aborted), 1);
        chk("abt4_cnt",  32'(beat_cnt), 4);
        chk("abt4_xfer", 32'(data_transfer), 0);
        chk("abt4_dma",  32'(dma_req), 0);
        tick();
        chk("abt4_idle_busy", 32'(busy), 0);
        chk("abt4_idle_abt",  32'(aborted), 0);
        chk("abt4_idle_cnt",  32'(beat_cnt), 4);

        // abort on the final beat is a normal completion
        start = 1'b1; burst_len = 8'd5;
        tick();
        start = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        chk("abt5_last_xfer", 32'(data_transfer), 1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abt5_done", 32'(done), 1);
        chk("abt5_abt",  32'(aborted), 0);
        chk("abt5_cnt",  32'(beat_cnt), 5);
        tick();
        chk("abt5_idle_busy", 32'(busy), 0);

        // abort during REQ
        start = 1'b1; burst_len = 8'd10;
        tick();
        start = 1'b0;
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abtreq_done", 32'(done), 1);
        chk("abtreq_abt",  32'(aborted), 1);
        chk("abtreq_cnt",  32'(beat_cnt), 0);
        tick();
        chk("abtreq_idle", 32'(busy), 0);

        // asynchronous reset at beat 20 of 50
        start = 1'b1; burst_len = 8'd50;
        tick();
        start = 1'b0;
        for (int i = 0; i < 20; i++) tick();
        chk("rstmid_cnt_before", 32'(beat_cnt), 19);
        chk("rstmid_xfer_before", 32'(data_transfer), 1);
        reset = 1'b1;
        #1;
        chk_all_zero("rstmid");
        tick();
        chk("rstmid_no_done", 32'(done), 0);
        reset = 1'b0;
        start = 1'b1; burst_len = 8'd3;
        tick();
        start = 1'b0;
        expect_burst("post_rst", 3);

        // start held high: back-to-back 2-beat bursts every 5 cycles
        start = 1'b1; burst_len = 8'd2;
        tick();
        for (int b = 0; b < 2; b++) begin
            for (int c = 0; c < 5; c++) begin
                chk("b2b_dma",  32'(dma_req), 32'(bb_req[c]));
                chk("b2b_xfer", 32'(data_transfer), 32'(bb_xfer[c]));
                chk("b2b_done", 32'(done), 32'(bb_done[c]));
                chk("b2b_busy", 32'(busy), 32'(bb_busy[c]));
                tick();
            end
        end
        start = 1'b0;
        expect_burst("b2b_last", 2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dma_burst_ctrl.md
DMA_BURST_CTRL -- requirements
Module: dma_burst_ctrl

Interface
REQ-001 Parameter LEN_W, default 8: width of the burst-length input and the beat counter.
REQ-002 Parameter DEF_LEN, default 100: burst length used when burst_len is 0 and use_def is high.
REQ-003 Port clk, input, 1: single clock; all state updates on posedge clk.
REQ-004 Port reset, input, 1: reset, asynchronous and active-high.
REQ-005 Port start, input, 1: request a burst; sampled only in IDLE.
REQ-006 Port burst_len, input, LEN_W: number of data beats, sampled with start.
REQ-007 Port use_def, input, 1: when high and burst_len==0, the beat count is DEF_LEN.
REQ-008 Port abort, input, 1: terminate the active burst.
REQ-009 Port dma_req, output, 1: DMA request, high from REQ through the end of XFER.
REQ-010 Port data_transfer, output, 1: beat-valid, high in every XFER cycle.
REQ-011 Port done, output, 1: one-cycle completion pulse.
REQ-012 Port aborted, output, 1: qualifies done; high when the burst ended by abort.
REQ-013 Port busy, output, 1: high in any state other than IDLE.
REQ-014 Port beat_cnt, output, LEN_W: beats completed in the current burst.
REQ-015 Port len_err, output, 1: one-cycle pulse when start is rejected for zero length.

Function
REQ-016 The FSM SHALL have states IDLE, REQ, XFER and DONE, and all outputs SHALL be registered.
REQ-017 IDLE: start && effective length != 0 SHALL latch the length, clear beat_cnt and go to REQ.
REQ-018 Effective length SHALL be burst_len if nonzero; otherwise DEF_LEN if use_def is high; otherwise 0.
REQ-019 IDLE: start with effective length 0 SHALL stay in IDLE and pulse len_err for 1 cycle.
REQ-020 REQ SHALL last exactly 1 cycle with dma_req=1 and data_transfer=0, then go to XFER.
REQ-021 XFER: dma_req=1 and data_transfer=1; beat_cnt SHALL increment once per cycle.
REQ-022 With latched length N, data_transfer SHALL be high for exactly N consecutive cycles, starting the cycle after dma_req rises.
REQ-023 Timing: start sampled at cycle T -> dma_req rises at T+1, data_transfer high T+2..T+1+N, done at T+2+N, IDLE at T+3+N.
REQ-024 DONE SHALL last 1 cycle with done=1, dma_req=0, data_transfer=0, then go to IDLE.
REQ-025 Abort in REQ or XFER SHALL go to DONE the next cycle with aborted=1; beat_cnt SHALL freeze.
REQ-026 Abort sampled on the final XFER beat SHALL be a normal completion with aborted=0.
REQ-027 Start outside IDLE SHALL be ignored, with no queuing.
REQ-028 Abort in IDLE or DONE SHALL be ignored.
REQ-029 beat_cnt SHALL hold its final value until the next accepted start.
REQ-030 beat_cnt SHALL never wrap, since N is at most 2^LEN_W-1.
REQ-031 DEF_LEN > 2^LEN_W-1 SHALL be a static elaboration error.

Reset
REQ-032 Asserting reset SHALL immediately force IDLE, with all outputs and beat_cnt at 0 and the latched length at 0.
REQ-033 Reset mid-burst SHALL drop dma_req and data_transfer asynchronously without producing a done pulse.
REQ-034 After reset deasserts, the first start SHALL be accepted on the first posedge at which it is sampled.

Structure
REQ-035 Package dma_pkg SHALL hold the state enum (IDLE, REQ, XFER, DONE) and the DEF_LEN default constant.
REQ-036 Sub-module dma_beat_cnt SHALL provide a loadable/clearable LEN_W counter with a last-beat flag (count == N-1).
REQ-037 The FSM SHALL use the last-beat flag to leave XFER.

Verification
REQ-038 burst_len=100, start pulse -> dma_req rises at T+1; data_transfer high 100 cycles; done=1, aborted=0 at T+102; beat_cnt=100.
REQ-039 burst_len=0, use_def=1 -> identical to the 100-beat case; burst_len=0, use_def=0 -> len_err pulse, busy stays 0.
REQ-040 burst_len=10, abort at the 4th beat -> done at the next cycle with aborted=1, beat_cnt=4.
REQ-041 burst_len=5, abort on the 5th beat -> done, aborted=0, beat_cnt=5.
REQ-042 burst_len=50, reset asserted at beat 20 -> all outputs 0 immediately, no done; a new start with burst_len=3 after reset gives 3 beats.
REQ-043 start held high continuously with burst_len=2 -> back-to-back bursts, one every 5 cycles (REQ, 2 XFER, DONE, IDLE); start ignored while busy.
